ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: the send side of the PS/2 link whose receive side is `ps2_keyboard`. It takes one command byte per handshake (e.g. 0xED set-LEDs, 0xFF reset) and drives the open-drain PS/2 clock and data lines through output-enable signals. It runs the inhibit, start, data, parity, stop and acknowledge sequence, then reports completion or error. It sits in `top` beside `ps2_keyboard`, sharing the same `io_ps2_clk`/`io_ps2_data` pins.

## Interface
- `INHIBIT_CYCLES`, default 5000: clock-low inhibit duration in `clock` cycles (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 750000: limit from clock release to acknowledge (15 ms at 50 MHz).

Ports:
- `clock`  in  1  system clock. One clock domain; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset.
- `tx_valid`  in  1  command byte is offered.
- `tx_data`  in  8  command byte.
- `tx_ready`  out  1  block is idle and can accept a byte.
- `tx_done`  out  1  one-cycle pulse at the end of a transaction.
- `tx_err`  out  1  valid only while `tx_done`=1; 1 means NACK or timeout.
- `ps2_clk_i`  in  1  raw PS/2 clock pin level (asynchronous).
- `ps2_data_i`  in  1  raw PS/2 data pin level (asynchronous).
- `ps2_clk_oe`  out  1  1 = pull the PS/2 clock low; 0 = release it.
- `ps2_data_oe`  out  1  1 = pull the PS/2 data low; 0 = release it.

## Operation
- **Synchronizers.** `ps2_clk_i` and `ps2_data_i` each pass through a 2-flop synchronizer. A third flop on clock gives `clk_fall` = previous synced 1 and current synced 0.
- **Handshake.** A byte is accepted when `tx_valid` && `tx_ready`.
  - The byte is latched together with odd parity, `par = ~^tx_data`.
  - `tx_ready` = (state == IDLE).
  - `tx_valid` while busy is ignored and not queued.
- **Shift order.** The frame is LSB first: D0..D7, then parity, then stop.
- **Line encoding.** A bit value of 0 sets `ps2_data_oe`=1; a bit value of 1 sets it to 0.

States:
- **IDLE**
  - Both OE = 0.
  - On accept, go to INHIBIT and clear the counter.
- **INHIBIT**
  - `ps2_clk_oe`=1, `ps2_data_oe`=0, for exactly INHIBIT_CYCLES cycles.
  - Then go to START.
- **START** (1 cycle)
  - `ps2_clk_oe`=1, `ps2_data_oe`=1 (start bit = 0).
  - Then go to SEND, clear the bit index and clear the timeout counter.
- **SEND**
  - `ps2_clk_oe`=0; `ps2_data_oe` holds the start bit until the first `clk_fall`.
  - Each `clk_fall` presents the next bit: falls 1–8 present D0..D7, fall 9 presents parity, fall 10 presents the stop bit (`ps2_data_oe`=0).
  - After fall 10, go to ACK.
- **ACK**
  - Both OE = 0.
  - On the next `clk_fall`, sample synced data: 0 means ACK, 1 means NACK and sets the error flag.
  - Go to WAIT_IDLE.
- **WAIT_IDLE**
  - Both OE = 0.
  - When synced clock and synced data are both 1, pulse `tx_done` with `tx_err` = error flag and go to IDLE.
- **Timeout**
  - The counter runs in SEND, ACK and WAIT_IDLE.
  - When it reaches TIMEOUT_CYCLES, release both lines, pulse `tx_done` with `tx_err`=1 and go to IDLE.
  - Timeout has priority over a `clk_fall` in the same cycle.
- **Reset** (including mid-transaction)
  - Next state is IDLE; both OE = 0.
  - The transaction is abandoned and no `tx_done` is issued.

## Timing
- **Reset values:** `tx_ready`=1, `tx_done`=0, `tx_err`=0, `ps2_clk_oe`=0, `ps2_data_oe`=0.
- **Accept to inhibit:** `ps2_clk_oe` rises in the cycle after the accept edge. `tx_ready` falls in that same cycle.
- **Clock release:** `ps2_clk_oe` falls INHIBIT_CYCLES+1 cycles after it rose. `ps2_data_oe` has already been high for 1 cycle at that point.
- **Bit update:** the data OE changes 1 cycle after `clk_fall` is detected, i.e. 3 cycles after the raw falling edge. It therefore settles well inside the device clock-low phase.
- **Completion:**
  - `tx_done` is high for exactly 1 cycle.
  - `tx_ready` returns to 1 in the cycle after `tx_done`.
  - A new accept is possible in that same cycle.
- **Glitch filtering:** none. The device clock runs at 10–16.7 kHz, far below `clock`.
- **Drive limits:** `ps2_clk_oe` is asserted only in INHIBIT and START. The block never drives either line high.

## Test plan
- **0xED with ACK.** Device model clocks at 12.5 kHz and pulls data low at fall 11.
  - Data line at falls 1–10 = 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - `tx_done`=1 with `tx_err`=0.
  - `ps2_clk_oe` high for 5000 cycles, then START for 1 cycle.
- **0x01 parity.** Parity driven 0 (`ps2_data_oe`=1 at fall 9). Same check with 0xFF: parity driven 1.
- **NACK.** Device leaves data high at fall 11, so `tx_err`=1 at `tx_done`.
- **Device silent.** No clock after release, so exactly TIMEOUT_CYCLES cycles later `tx_done`=1 and `tx_err`=1, with both OE = 0.
- **`tx_valid` held through a transfer.**
  - Only one accept occurs; a second byte 0x02 is accepted in the cycle after `tx_done`.
- **Reset during SEND after fall 4.**
  - Both OE = 0 and `tx_ready`=1 on the next cycle.
  - No `tx_done` ever appears.
  - The following 0xF4 transfers correctly.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. Accepts one command byte per valid/ready
// handshake and sends it to the device over the open-drain PS/2 clock and
// data lines. The sequence is: inhibit the clock, drive the start bit, then
// shift D0..D7, odd parity and stop on device clock falls, and finally
// sample the device acknowledge.
//
// Ports
//   clock        system clock (single domain)
//   reset        synchronous, active-high reset
//   tx_valid     command byte offered
//   tx_data      command byte
//   tx_ready     idle, a byte can be accepted this cycle
//   tx_done      one-cycle pulse at the end of a transaction
//   tx_err       with tx_done: 1 = NACK or timeout
//   ps2_clk_i    raw PS/2 clock pin (asynchronous)
//   ps2_data_i   raw PS/2 data pin (asynchronous)
//   ps2_clk_oe   1 = pull PS/2 clock low
//   ps2_data_oe  1 = pull PS/2 data low
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE
  } state_t;

  state_t         state_q;
  logic [2:0]     clk_sync_q;
  logic [1:0]     data_sync_q;
  logic [9:0]     frame_q;      // {stop, parity, D7..D0}, shifted out LSB first
  logic [3:0]     bit_idx_q;    // number of device clock falls seen in SEND
  logic [CW-1:0]  cnt_q;        // inhibit counter, then release-to-finish timeout
  logic           clk_oe_q;
  logic           data_oe_q;
  logic           done_q;
  logic           err_q;
  logic           nack_q;

  logic clk_s;
  logic data_s;
  logic clk_fall;
  logic timeout;

  // Two-flop synchronizers; the third clock flop gives the previous synced level.
  // Reset to 1 because idle PS/2 lines float high.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
    end
  end

  assign clk_s    = clk_sync_q[1];
  assign data_s   = data_sync_q[1];
  assign clk_fall = clk_sync_q[2] & ~clk_sync_q[1];

  // The timeout window covers everything after the clock is released.
  assign timeout = (cnt_q == TMO_LAST) &&
                   ((state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (timeout) begin
        // Timeout wins over a clock fall arriving in the same cycle.
        state_q   <= S_DONE;
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        done_q    <= 1'b1;
        err_q     <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            if (tx_valid) begin
              frame_q  <= {1'b1, ~^tx_data, tx_data};
              cnt_q    <= '0;
              nack_q   <= 1'b0;
              clk_oe_q <= 1'b1;
              state_q  <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (cnt_q == INH_LAST) begin
              data_oe_q <= 1'b1;     // start bit goes out one cycle before clock release
              state_q   <= S_START;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_START: begin
            clk_oe_q  <= 1'b0;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= S_SEND;
          end
          S_SEND: begin
            cnt_q <= cnt_q + 1'b1;
            if (clk_fall) begin
              // A 0 bit pulls the line low; a 1 bit releases it.
              data_oe_q <= ~frame_q[0];
              frame_q   <= {1'b0, frame_q[9:1]};
              bit_idx_q <= bit_idx_q + 1'b1;
              if (bit_idx_q == 4'd9) begin
                state_q <= S_ACK;
              end
            end
          end
          S_ACK: begin
            cnt_q     <= cnt_q + 1'b1;
            data_oe_q <= 1'b0;
            if (clk_fall) begin
              nack_q  <= data_s;
              state_q <= S_WAIT_IDLE;
            end
          end
          S_WAIT_IDLE: begin
            cnt_q <= cnt_q + 1'b1;
            if (clk_s && data_s) begin
              done_q  <= 1'b1;
              err_q   <= nack_q;
              state_q <= S_DONE;
            end
          end
          // Holds tx_ready low during the tx_done cycle.
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: an open-drain line model plus a behavioural
// PS/2 device that clocks the frame, collects the bits the host drives and
// answers with ACK, NACK, silence or is interrupted by a reset.
module tb_ps2_host_tx;

  localparam int INH  = 200;
  localparam int TMO  = 3000;
  localparam int HALF = 20;    // device clock half period in system cycles

  localparam int M_ACK    = 0;
  localparam int M_NACK   = 1;
  localparam int M_SILENT = 2;
  localparam int M_RESET  = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       dev_clk_low;
  logic       dev_data_low;

  // Wired-AND open-drain lines with pull-ups.
  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference frame: data LSB first, odd parity over data, stop = 1.
  function automatic logic [9:0] frame_of(input logic [7:0] d);
    logic [9:0] f;
    f[7:0] = d;
    f[8]   = (($countones(d) % 2) == 0);
    f[9]   = 1'b1;
    return f;
  endfunction

  task automatic run_tx(input logic [7:0] d, input int mode, input bit hold, input logic [7:0] next_d);
    logic [9:0] exp_f;
    logic [9:0] got_f;
    int k;
    int oe_cycles;
    int data_cycles;
    int n_done;
    exp_f = frame_of(d);
    got_f = '0;
    check_eq("ready_before", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    check_eq("accept_clk_oe", ps2_clk_oe, 1);
    check_eq("accept_ready", tx_ready, 0);
    if (hold) tx_data = ~d;   // a busy block must not pick this up
    else      tx_valid = 1'b0;

    oe_cycles   = 0;
    data_cycles = 0;
    while (ps2_clk_oe === 1'b1 && oe_cycles < INH + 50) begin
      oe_cycles++;
      if (ps2_data_oe === 1'b1) data_cycles++;
      tick();
    end
    check_eq("inhibit_len", oe_cycles, INH + 1);
    check_eq("start_len", data_cycles, 1);
    check_eq("start_held", ps2_data_oe, 1);

    if (mode == M_SILENT) begin
      k = 0;
      while (tx_done !== 1'b1 && k < TMO + 20) begin
        tick();
        k++;
      end
      check_eq("timeout_len", k, TMO);
      check_eq("timeout_err", tx_err, 1);
      check_eq("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    end else begin
      repeat (HALF) tick();
      for (int i = 0; i < 10; i++) begin
        if (mode == M_RESET && i == 4) break;
        dev_clk_low = 1'b1;
        repeat (HALF - 2) tick();
        got_f[i] = ps2_data_i;
        repeat (2) tick();
        dev_clk_low = 1'b0;
        repeat (HALF) tick();
      end
      if (mode == M_RESET) begin
        check_eq("partial_frame", got_f[3:0], exp_f[3:0]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check_eq("reset_ready", tx_ready, 1);
        n_done = 0;
        repeat (HALF * 12) begin
          tick();
          if (tx_done === 1'b1) n_done++;
        end
        check_eq("reset_no_done", n_done, 0);
      end else begin
        check_eq("frame", got_f, exp_f);
        if (mode == M_ACK) dev_data_low = 1'b1;
        repeat (5) tick();
        dev_clk_low = 1'b1;
        repeat (HALF / 2) tick();
        check_eq("ack_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        repeat (HALF / 2) tick();
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        k = 0;
        while (tx_done !== 1'b1 && k < 50) begin
          tick();
          k++;
        end
        check_eq("done_seen", tx_done, 1);
        check_eq("done_err", tx_err, (mode == M_NACK) ? 1 : 0);
      end
    end

    if (mode != M_RESET) begin
      check_eq("done_ready", tx_ready, 0);
      if (hold) tx_data = next_d;
      tick();
      check_eq("done_pulse", tx_done, 0);
      check_eq("ready_after", tx_ready, 1);
    end
    $display("tx %02h mode %0d hold %0d done (checks %0d, failures %0d)", d, mode, hold, n_checks, n_fail);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    int rm;
    reset        = 1'b1;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) tick();
    check_eq("rst_ready", tx_ready, 1);
    check_eq("rst_done", tx_done, 0);
    check_eq("rst_err", tx_err, 0);
    check_eq("rst_clk_oe", ps2_clk_oe, 0);
    check_eq("rst_data_oe", ps2_data_oe, 0);
    reset = 1'b0;
    tick();

    run_tx(8'hED, M_ACK, 1'b0, 8'h00);
    run_tx(8'h01, M_ACK, 1'b0, 8'h00);
    run_tx(8'hFF, M_ACK, 1'b0, 8'h00);
    run_tx(8'h3C, M_NACK, 1'b0, 8'h00);
    run_tx(8'h55, M_SILENT, 1'b0, 8'h00);
    run_tx(8'hAB, M_ACK, 1'b1, 8'h02);
    run_tx(8'h02, M_ACK, 1'b0, 8'h00);
    run_tx(8'h77, M_RESET, 1'b0, 8'h00);
    run_tx(8'hF4, M_ACK, 1'b0, 8'h00);
    for (int n = 0; n < 6; n++) begin
      rd = 8'($urandom_range(0, 255));
      rm = int'($urandom_range(0, 1));
      run_tx(rd, rm, 1'b0, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
